// File: rtl/sd_cmd_master_if.sv
// Handshake and payload bundle between the command sequencer and the SD command serial engine.
interface sd_cmd_master_if;
  logic [15:0] setting_o;
  logic [39:0] cmd_o;
  logic        req_o;
  logic        ack_o;
  logic        ack_i;
  logic        req_i;
  logic [7:0]  status_i;
  logic [39:0] resp_i;

  modport master (
    output setting_o, cmd_o, req_o, ack_o,
    input  ack_i, req_i, status_i, resp_i
  );

  modport slave (
    input  setting_o, cmd_o, req_o, ack_o,
    output ack_i, req_i, status_i, resp_i
  );
endinterface

// File: rtl/sd_cmd_master.sv
// SD command sequencer: arbitrates SW/DM command jobs (DM first), drives the serial
// engine through its REQ/ACK handshake and returns the response or timeout/CRC error.
module sd_cmd_master #(
  parameter int unsigned          TIMEOUT_W   = 16,
  parameter logic [TIMEOUT_W-1:0] TIMEOUT_MAX = '1
) (
  input  logic        SD_CLK_IN,
  input  logic        RST_IN,
  input  logic        sw_start_i,
  input  logic [5:0]  sw_index_i,
  input  logic [31:0] sw_arg_i,
  input  logic [15:0] sw_setting_i,
  output logic        sw_done_o,
  input  logic        dm_start_i,
  input  logic [5:0]  dm_index_i,
  input  logic [31:0] dm_arg_i,
  input  logic [15:0] dm_setting_i,
  output logic        dm_done_o,
  output logic [31:0] resp_o,
  output logic [1:0]  err_o,
  output logic        busy_o,
  sd_cmd_master_if.master eng
);

  localparam int unsigned PHASE_W = 4;
  localparam logic [PHASE_W-1:0] PHASE_RESP   = 4'b0110;
  localparam logic [PHASE_W-1:0] PHASE_NORESP = 4'b0100;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_REQ  = 3'd2,
    S_WAIT = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t               state;
  logic                 grant_dm;
  logic                 ro;
  logic                 fin;
  logic                 req_q;
  logic [TIMEOUT_W-1:0] wd;
  logic                 report_final_c;
  logic                 unused_bits;

  // A report is final only once the engine flags it finished with the expected phase.
  assign report_final_c = eng.status_i[6] &&
                          (eng.status_i[3:0] == (ro ? PHASE_RESP : PHASE_NORESP));
  assign unused_bits    = ^{eng.status_i[7], eng.status_i[4], eng.resp_i[39:32]};

  always_ff @(posedge SD_CLK_IN) begin
    if (!RST_IN) begin
      state         <= S_IDLE;
      grant_dm      <= 1'b0;
      ro            <= 1'b0;
      fin           <= 1'b0;
      req_q         <= 1'b0;
      wd            <= '0;
      sw_done_o     <= 1'b0;
      dm_done_o     <= 1'b0;
      resp_o        <= '0;
      err_o         <= '0;
      busy_o        <= 1'b0;
      eng.setting_o <= '0;
      eng.cmd_o     <= '0;
      eng.req_o     <= 1'b0;
      eng.ack_o     <= 1'b0;
    end else begin
      sw_done_o <= 1'b0;
      dm_done_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (eng.ack_i && (dm_start_i || sw_start_i)) begin
            grant_dm <= dm_start_i;
            busy_o   <= 1'b1;
            state    <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (grant_dm) begin
            eng.cmd_o     <= {2'b01, dm_index_i, dm_arg_i};
            eng.setting_o <= dm_setting_i;
            ro            <= |dm_setting_i[6:0];
          end else begin
            eng.cmd_o     <= {2'b01, sw_index_i, sw_arg_i};
            eng.setting_o <= sw_setting_i;
            ro            <= |sw_setting_i[6:0];
          end
          eng.req_o <= 1'b1;
          state     <= S_REQ;
        end
        S_REQ: begin
          if (!eng.ack_i) begin
            eng.req_o <= 1'b0;
            wd        <= '0;
            req_q     <= 1'b0;
            fin       <= 1'b0;
            state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          req_q <= eng.req_i;
          if (fin) begin
            // Final report acknowledged: hold ACK until the engine returns to idle.
            if (eng.ack_i) begin
              eng.ack_o <= 1'b0;
              busy_o    <= 1'b0;
              if (grant_dm) dm_done_o <= 1'b1;
              else          sw_done_o <= 1'b1;
              state     <= S_DONE;
            end
          end else if (eng.req_i && report_final_c) begin
            fin       <= 1'b1;
            eng.ack_o <= 1'b1;
            if (ro) begin
              resp_o <= eng.resp_i[31:0];
              err_o  <= {eng.setting_o[7] & ~eng.status_i[5], 1'b0};
            end else begin
              resp_o <= '0;
              err_o  <= '0;
            end
          end else if (wd == TIMEOUT_MAX) begin
            err_o     <= 2'b01;
            resp_o    <= '0;
            eng.ack_o <= 1'b1;
            busy_o    <= 1'b0;
            if (grant_dm) dm_done_o <= 1'b1;
            else          sw_done_o <= 1'b1;
            state     <= S_DONE;
          end else begin
            eng.ack_o <= eng.req_i;
            if (eng.req_i && !req_q) wd <= '0;
            else                     wd <= wd + TIMEOUT_W'(1);
          end
        end
        S_DONE: begin
          eng.ack_o <= 1'b0;
          grant_dm  <= 1'b0;
          fin       <= 1'b0;
          state     <= S_IDLE;
        end
        default: begin
          eng.req_o <= 1'b0;
          eng.ack_o <= 1'b0;
          busy_o    <= 1'b0;
          grant_dm  <= 1'b0;
          fin       <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sd_cmd_master.sv
// Directed bench for sd_cmd_master: a scripted engine model answers each job and the
// expected command words, responses and error codes are written out by hand.
module tb_sd_cmd_master;
  localparam logic [15:0] TMAX  = 16'd64;
  localparam int          LIMIT = 200;
  localparam int SIG_REQ = 0, SIG_ACK = 1, SIG_DONE = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sw_start, dm_start, sw_done, dm_done, busy;
  logic [5:0]  sw_index, dm_index;
  logic [31:0] sw_arg, dm_arg, resp;
  logic [15:0] sw_setting, dm_setting;
  logic [1:0]  err;
  int          n_tests = 0;
  int          n_fail  = 0;

  sd_cmd_master_if eng_if ();

  sd_cmd_master #(.TIMEOUT_W(16), .TIMEOUT_MAX(TMAX)) dut (
    .SD_CLK_IN   (clk),
    .RST_IN      (rst_n),
    .sw_start_i  (sw_start),
    .sw_index_i  (sw_index),
    .sw_arg_i    (sw_arg),
    .sw_setting_i(sw_setting),
    .sw_done_o   (sw_done),
    .dm_start_i  (dm_start),
    .dm_index_i  (dm_index),
    .dm_arg_i    (dm_arg),
    .dm_setting_i(dm_setting),
    .dm_done_o   (dm_done),
    .resp_o      (resp),
    .err_o       (err),
    .busy_o      (busy),
    .eng         (eng_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      SIG_REQ: return eng_if.req_o;
      SIG_ACK: return eng_if.ack_o;
      default: return sw_done | dm_done;
    endcase
  endfunction

  task automatic wait_for(input int sel, input logic val, input string tag);
    int n = 0;
    while (sig(sel) !== val && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_wait"}, 64'(sig(sel)), 64'(val));
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_cmd"},  64'(eng_if.cmd_o), 64'h0);
    check({tag, "_set"},  64'(eng_if.setting_o), 64'h0);
    check({tag, "_resp"}, 64'(resp), 64'h0);
    check({tag, "_err"},  64'(err), 64'h0);
    check({tag, "_hs"},   64'({eng_if.req_o, eng_if.ack_o, busy, sw_done, dm_done}), 64'h0);
  endtask

  // Issue handshake and wait for the DUT to enter WAIT.
  task automatic handshake(input string tag, input logic [39:0] exp_cmd, input logic [15:0] exp_set);
    wait_for(SIG_REQ, 1'b1, {tag, "_req"});
    check({tag, "_cmd"}, 64'(eng_if.cmd_o), 64'(exp_cmd));
    check({tag, "_set"}, 64'(eng_if.setting_o), 64'(exp_set));
    check({tag, "_busy"}, 64'(busy), 64'h1);
    repeat (2) @(negedge clk);
    check({tag, "_reqhold"}, 64'(eng_if.req_o), 64'h1);
    eng_if.ack_i = 1'b0;
    wait_for(SIG_REQ, 1'b0, {tag, "_reqdrop"});
  endtask

  task automatic serve(input string tag, input logic dm_exp, input logic [39:0] exp_cmd,
                       input logic [15:0] exp_set, input logic [7:0] pre_st, input logic [7:0] fin_st,
                       input logic [39:0] resp_word, input logic [31:0] exp_resp, input logic [1:0] exp_err);
    handshake(tag, exp_cmd, exp_set);
    if (pre_st != 8'h00) begin
      eng_if.status_i = pre_st;
      eng_if.req_i    = 1'b1;
      wait_for(SIG_ACK, 1'b1, {tag, "_preack"});
      eng_if.req_i = 1'b0;
      wait_for(SIG_ACK, 1'b0, {tag, "_preackdrop"});
      check({tag, "_prebusy"}, 64'(busy), 64'h1);
    end
    eng_if.status_i = fin_st;
    eng_if.resp_i   = resp_word;
    eng_if.req_i    = 1'b1;
    wait_for(SIG_ACK, 1'b1, {tag, "_finack"});
    eng_if.req_i = 1'b0;
    repeat (2) @(negedge clk);
    check({tag, "_ackhold"}, 64'({eng_if.ack_o, sw_done, dm_done}), 64'b100);
    eng_if.ack_i = 1'b1;
    wait_for(SIG_DONE, 1'b1, {tag, "_done"});
    check({tag, "_who"},  64'({dm_done, sw_done}), dm_exp ? 64'b10 : 64'b01);
    check({tag, "_resp"}, 64'(resp), 64'(exp_resp));
    check({tag, "_err"},  64'(err), 64'(exp_err));
    check({tag, "_end"},  64'({busy, eng_if.ack_o}), 64'h0);
    if (dm_exp) dm_start = 1'b0;
    else        sw_start = 1'b0;
    @(negedge clk);
    check({tag, "_pulse"}, 64'({sw_done, dm_done}), 64'h0);
  endtask

  task automatic sw_job(input logic [5:0] idx, input logic [31:0] arg, input logic [15:0] set);
    sw_index = idx; sw_arg = arg; sw_setting = set; sw_start = 1'b1;
  endtask

  initial begin
    int cnt;
    int dones;
    rst_n = 1'b0;
    sw_start = 1'b0; dm_start = 1'b0;
    sw_index = '0; sw_arg = '0; sw_setting = '0;
    dm_index = '0; dm_arg = '0; dm_setting = '0;
    eng_if.ack_i = 1'b1; eng_if.req_i = 1'b0;
    eng_if.status_i = '0; eng_if.resp_i = '0;
    repeat (3) @(negedge clk);
    check_idle("rst");
    rst_n = 1'b1;
    @(negedge clk);

    sw_job(6'd0, 32'h0, 16'h0000);
    serve("cmd0", 1'b0, 40'h4000000000, 16'h0000, 8'h04, 8'h44, 40'h0, 32'h0, 2'b00);

    sw_job(6'd8, 32'h000001AA, 16'h00AD);
    serve("cmd8", 1'b0, 40'h48000001AA, 16'h00AD, 8'h00, 8'h66, 40'h08000001AA, 32'h000001AA, 2'b00);

    sw_job(6'd8, 32'h000001AA, 16'h00AD);
    serve("cmd8crc", 1'b0, 40'h48000001AA, 16'h00AD, 8'h00, 8'h46, 40'h08000001AA, 32'h000001AA, 2'b10);

    sw_job(6'd8, 32'h000001AA, 16'h002D);
    serve("cmd8nochk", 1'b0, 40'h48000001AA, 16'h002D, 8'h00, 8'h46, 40'h08000001AA, 32'h000001AA, 2'b00);

    // Simultaneous requests: DM first, SW right after.
    dm_index = 6'd17; dm_arg = 32'h12345678; dm_setting = 16'h0000;
    sw_job(6'd55, 32'h0, 16'h0100);
    dm_start = 1'b1;
    serve("arb_dm", 1'b1, 40'h5112345678, 16'h0000, 8'h00, 8'h44, 40'h0, 32'h0, 2'b00);
    serve("arb_sw", 1'b0, 40'h7700000000, 16'h0100, 8'h04, 8'h44, 40'h0, 32'h0, 2'b00);

    // Engine goes silent after the handshake.
    sw_job(6'd8, 32'h000001AA, 16'h00AD);
    handshake("tmo", 40'h48000001AA, 16'h00AD);
    cnt = 0;
    while (!sw_done && cnt < 32'(TMAX) + 20) begin
      @(negedge clk);
      cnt++;
    end
    check("tmo_done", 64'(sw_done), 64'h1);
    check("tmo_lat", 64'(cnt >= 32'(TMAX) && cnt <= 32'(TMAX) + 2), 64'h1);
    check("tmo_err", 64'(err), 64'h1);
    check("tmo_resp", 64'(resp), 64'h0);
    check("tmo_ack", 64'(eng_if.ack_o), 64'h1);
    sw_start = 1'b0;
    eng_if.ack_i = 1'b1;
    @(negedge clk);
    check("tmo_ackpulse", 64'({eng_if.ack_o, sw_done}), 64'h0);
    @(negedge clk);

    // Reset in the middle of WAIT.
    sw_job(6'd8, 32'h000001AA, 16'h00AD);
    handshake("abort", 40'h48000001AA, 16'h00AD);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    sw_start = 1'b0;
    @(negedge clk);
    check_idle("abort_rst");
    rst_n = 1'b1;
    eng_if.ack_i = 1'b1;
    dones = 0;
    repeat (6) begin
      @(negedge clk);
      if (sw_done || dm_done) dones++;
    end
    check("abort_nodone", 64'(dones), 64'h0);
    sw_job(6'd0, 32'h0, 16'h0000);
    serve("after_rst", 1'b0, 40'h4000000000, 16'h0000, 8'h04, 8'h44, 40'h0, 32'h0, 2'b00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
